// File: rtl/pipelined_chunk_addsub.sv
// Multi-cycle WIDTH-bit add/sub, one CHUNK-bit slice per cycle with a registered inter-slice carry.
// Result valid NCH cycles after accept; accepts nothing until the result is taken (out_valid & out_ready).
module pipelined_chunk_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("pipelined_chunk_addsub: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, bx_r, sum_r, sum_nxt;
  logic             carry_r;
  logic [CW-1:0]    cnt;
  logic [CHUNK:0]   slice;
  logic             msb_cin;
  logic             cout_r, ovf_r, zero_r, neg_r;
  int               base;

  // Current slice result merged into the running sum so the final edge sees the full word.
  always_comb begin
    base    = int'(cnt) * CHUNK;
    slice   = {1'b0, a_r[base +: CHUNK]} + {1'b0, bx_r[base +: CHUNK]} + {{CHUNK{1'b0}}, carry_r};
    sum_nxt = sum_r;
    sum_nxt[base +: CHUNK] = slice[CHUNK-1:0];
    msb_cin = a_r[WIDTH-1] ^ bx_r[WIDTH-1] ^ sum_nxt[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= '0;
      bx_r    <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      // Subtraction is A + ~B + 1: invert B here and inject the +1 as slice 0 carry-in.
      a_r     <= a;
      bx_r    <= b ^ {WIDTH{op}};
      carry_r <= op;
      cnt     <= '0;
    end else if (state == CALC) begin
      sum_r   <= sum_nxt;
      carry_r <= slice[CHUNK];
      cnt     <= cnt + 1'b1;
      if (cnt == LAST) begin
        cout_r <= slice[CHUNK];
        ovf_r  <= msb_cin ^ slice[CHUNK];
        zero_r <= (sum_nxt == '0);
        neg_r  <= sum_nxt[WIDTH-1];
      end
    end
  end

  assign sum      = sum_r;
  assign cout     = cout_r;
  assign overflow = ovf_r;
  assign zero     = zero_r;
  assign negative = neg_r;

endmodule
